rf_wb_ctrl: RTL

Write-back controller that drives the register-file write port (we/wa/wd) from two producers: the in-order pipeline WB stage and the multi-cycle mul/div unit (MDU). It arbitrates the two producers, buffers MDU results in a small FIFO, and emits at most one register write per cycle. It also keeps a per-register busy scoreboard of outstanding MDU destinations for the hazard unit.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_wb_ctrl_if.sv | 52 +++++
 rtl/wb_fifo.sv | 59 +++++
 rtl/rf_wb_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

   localparam int unsigned REG_NUM  = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned DATA_W   = 32;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bus bundle between the write-back controller and its producers/consumers.
// Carries dbg_commit_cnt only when WB_COMMIT_CNT_EN is defined.
interface rf_wb_ctrl_if
   import rf_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) ();

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                pipe_valid;
   logic                pipe_ready;
   logic [REG_AW-1:0]   pipe_wa;
   logic [DATA_W-1:0]   pipe_wd;
   logic                mdu_issue_valid;
   logic [REG_AW-1:0]   mdu_issue_rd;
   logic                mdu_valid;
   logic                mdu_ready;
   logic [REG_AW-1:0]   mdu_wa;
   logic [DATA_W-1:0]   mdu_wd;
   logic                rf_we;
   logic [REG_AW-1:0]   rf_wa;
   logic [DATA_W-1:0]   rf_wd;
   logic [REG_NUM-1:0]  busy;
   logic [CNT_W-1:0]    fifo_cnt;
`ifdef WB_COMMIT_CNT_EN
   logic [31:0]         dbg_commit_cnt;
`endif

   modport master (
      output pipe_valid, pipe_wa, pipe_wd,
      output mdu_issue_valid, mdu_issue_rd,
      output mdu_valid, mdu_wa, mdu_wd,
      input  pipe_ready, mdu_ready,
      input  rf_we, rf_wa, rf_wd, busy, fifo_cnt
`ifdef WB_COMMIT_CNT_EN
      , input dbg_commit_cnt
`endif
   );

   modport slave (
      input  pipe_valid, pipe_wa, pipe_wd,
      input  mdu_issue_valid, mdu_issue_rd,
      input  mdu_valid, mdu_wa, mdu_wd,
      output pipe_ready, mdu_ready,
      output rf_we, rf_wa, rf_wd, busy, fifo_cnt
`ifdef WB_COMMIT_CNT_EN
      , output dbg_commit_cnt
`endif
   );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; DEPTH must be a power of two >= 2.
module wb_fifo
   import rf_pkg::*;
#(
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  wb_req_t       data_i,
   input  logic          pop_i,
   output wb_req_t       data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] cnt_o
);

   wb_req_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: arbitrates pipeline vs buffered MDU results,
// tracks outstanding MDU destinations. Optional WB_COMMIT_CNT_EN adds a commit counter.
module rf_wb_ctrl
   import rf_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic         clk,
   input logic         rst,
   rf_wb_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

   wb_req_t             pipe_req, mdu_req, head;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_cnt;
   logic                force_c, pipe_grant_c, fifo_grant_c, push_c;

   logic [SW-1:0]       starve_q, starve_d;
   logic                we_q, we_d;
   logic [REG_AW-1:0]   wa_q, wa_d;
   logic [DATA_W-1:0]   wd_q, wd_d;
   logic [REG_NUM-1:0]  busy_q, busy_d;

   assign pipe_req = '{wa: bus.pipe_wa, wd: bus.pipe_wd};
   assign mdu_req  = '{wa: bus.mdu_wa,  wd: bus.mdu_wd};

   // Forced FIFO slot once it has lost arbitration STARVE_LIMIT times in a row
   assign force_c      = (starve_q == SW'(STARVE_LIMIT));
   assign pipe_grant_c = bus.pipe_valid && !force_c;
   assign fifo_grant_c = !fifo_empty && (force_c || !bus.pipe_valid);
   assign push_c       = bus.mdu_valid && !fifo_full;

   wb_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .data_i  (mdu_req),
      .pop_i   (fifo_grant_c),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (fifo_cnt)
   );

   always_comb begin
      starve_d = starve_q;
      we_d     = 1'b0;
      wa_d     = wa_q;
      wd_d     = wd_q;
      busy_d   = busy_q;

      if (fifo_empty || fifo_grant_c) begin
         starve_d = '0;
      end else if (!force_c) begin
         starve_d = starve_q + SW'(1);
      end

      // x0 results complete their handshake but never reach the regfile
      if (pipe_grant_c) begin
         if (pipe_req.wa != REG_ZERO) begin
            we_d = 1'b1;
            wa_d = pipe_req.wa;
            wd_d = pipe_req.wd;
         end
      end else if (fifo_grant_c) begin
         if (head.wa != REG_ZERO) begin
            we_d         = 1'b1;
            wa_d         = head.wa;
            wd_d         = head.wd;
            busy_d[head.wa] = 1'b0;
         end
      end

      // A new issue to the same register outranks the retiring result
      if (bus.mdu_issue_valid && (bus.mdu_issue_rd != REG_ZERO)) begin
         busy_d[bus.mdu_issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
         we_q     <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
         busy_q   <= '0;
      end else begin
         starve_q <= starve_d;
         we_q     <= we_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
         busy_q   <= busy_d;
      end
   end

`ifdef WB_COMMIT_CNT_EN
   logic [31:0] commit_q, commit_d;

   always_comb begin
      commit_d = commit_q;
      if (we_q) commit_d = commit_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) commit_q <= '0;
      else     commit_q <= commit_d;
   end

   assign bus.dbg_commit_cnt = commit_q;
`endif

   assign bus.pipe_ready = !force_c;
   assign bus.mdu_ready  = !fifo_full;
   assign bus.rf_we      = we_q;
   assign bus.rf_wa      = wa_q;
   assign bus.rf_wd      = wd_q;
   assign bus.busy       = busy_q;
   assign bus.fifo_cnt   = fifo_cnt;

endmodule
